coin_track: RTL and testbench

COIN_TRACK -- requirements
Module: coin_track

---
 rtl/coin_if.sv | 27 ++
 rtl/coin_track.sv | 139 +++++++++++++
 tb/tb_coin_track.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/coin_if.sv
// Signal bundle between the coin tracker and the game logic around it.
// The clock and reset are not part of this bundle; they are separate plain ports.
interface coin_if;
   logic               frame_tick_i;
   logic               enable_i;
   logic [1:0]         player_lane_i;
   logic [3:0]         rand_i;
   logic signed [11:0] coinloc_o;
   logic [1:0]         coin_lane_o;
   logic               coin_visible_o;
   logic               coin_hit_o;
   logic [15:0]        score_o;
   logic [3:0]         misses_o;
   logic               game_over_o;

   modport slave (
      input  frame_tick_i, enable_i, player_lane_i, rand_i,
      output coinloc_o, coin_lane_o, coin_visible_o, coin_hit_o,
             score_o, misses_o, game_over_o
   );

   modport master (
      output frame_tick_i, enable_i, player_lane_i, rand_i,
      input  coinloc_o, coin_lane_o, coin_visible_o, coin_hit_o,
             score_o, misses_o, game_over_o
   );
endinterface

// File: rtl/coin_track.sv
// Coin spawner and tracker: moves one coin down a lane per frame and
// scores hits and misses against the player lane until the game ends.
module coin_track #(
   parameter int START_LOC  = -50,
   parameter int SPEED      = 1,
   parameter int HIT_LO     = 50,
   parameter int HIT_HI     = 55,
   parameter int END_LOC    = 60,
   parameter int MAX_MISSES = 3
) (
   input  logic  clk,
   input  logic  rst,
   coin_if.slave trk
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MOVE, S_OVER} state_t;

   localparam logic signed [11:0] START_L  = 12'(START_LOC);
   localparam logic signed [12:0] HIT_LO_L = 13'(HIT_LO);
   localparam logic signed [12:0] HIT_HI_L = 13'(HIT_HI);
   localparam logic signed [12:0] END_L    = 13'(END_LOC);
   localparam logic signed [12:0] SPEED_L  = 13'(SPEED);
   localparam logic [3:0]         MAX_L    = 4'(MAX_MISSES);

   state_t             state_q;
   logic signed [11:0] coinloc_q;
   logic [1:0]         coin_lane_q;
   logic               coin_visible_q;
   logic               coin_hit_q;
   logic [15:0]        score_q;
   logic [3:0]         misses_q;
   logic               game_over_q;
   logic [2:0]         delay_q;

   logic signed [12:0] loc_ext;
   logic signed [12:0] loc_adv;
   logic [1:0]         eff_lane;
   logic [1:0]         spawn_lane;
   logic [2:0]         reload;
   logic [3:0]         misses_inc;
   logic               hit;
   logic               miss;

   // One extra bit of headroom so the advance compare cannot wrap.
   assign loc_ext    = {coinloc_q[11], coinloc_q};
   assign loc_adv    = loc_ext + SPEED_L;
   assign eff_lane   = (trk.player_lane_i == 2'd3) ? 2'd1 : trk.player_lane_i;
   assign spawn_lane = (trk.rand_i[1:0] == 2'd3) ? 2'd1 : trk.rand_i[1:0];
   assign reload     = {1'b0, trk.rand_i[3:2]} + 3'd1;
   assign misses_inc = misses_q + 4'd1;
   assign hit        = (loc_ext >= HIT_LO_L) && (loc_ext <= HIT_HI_L) && (coin_lane_q == eff_lane);
   assign miss       = (loc_adv >= END_L);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         coinloc_q      <= START_L;
         coin_lane_q    <= 2'd1;
         coin_visible_q <= 1'b0;
         coin_hit_q     <= 1'b0;
         score_q        <= 16'd0;
         misses_q       <= 4'd0;
         game_over_q    <= 1'b0;
         delay_q        <= 3'd0;
      end else begin
         coin_hit_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               coinloc_q      <= START_L;
               coin_visible_q <= 1'b0;
               if (trk.frame_tick_i && trk.enable_i) begin
                  delay_q <= reload;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (!trk.enable_i) begin
                  coinloc_q      <= START_L;
                  coin_visible_q <= 1'b0;
                  state_q        <= S_IDLE;
               end else if (trk.frame_tick_i) begin
                  delay_q <= delay_q - 3'd1;
                  if (delay_q <= 3'd1) begin
                     delay_q        <= 3'd0;
                     coinloc_q      <= 12'sd0;
                     coin_lane_q    <= spawn_lane;
                     coin_visible_q <= 1'b1;
                     state_q        <= S_MOVE;
                  end
               end
            end
            S_MOVE: begin
               if (!trk.enable_i) begin
                  coinloc_q      <= START_L;
                  coin_visible_q <= 1'b0;
                  state_q        <= S_IDLE;
               end else if (trk.frame_tick_i) begin
                  // A hit wins over a miss on the same frame.
                  if (hit) begin
                     coin_hit_q     <= 1'b1;
                     score_q        <= (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
                     coin_visible_q <= 1'b0;
                     coinloc_q      <= START_L;
                     delay_q        <= reload;
                     state_q        <= S_WAIT;
                  end else if (miss) begin
                     misses_q       <= misses_inc;
                     coin_visible_q <= 1'b0;
                     coinloc_q      <= START_L;
                     if (misses_inc == MAX_L) begin
                        game_over_q <= 1'b1;
                        state_q     <= S_OVER;
                     end else begin
                        delay_q <= reload;
                        state_q <= S_WAIT;
                     end
                  end else begin
                     coinloc_q <= loc_adv[11:0];
                  end
               end
            end
            default: begin
               game_over_q    <= 1'b1;
               coin_visible_q <= 1'b0;
               coinloc_q      <= START_L;
            end
         endcase
      end
   end

   assign trk.coinloc_o      = coinloc_q;
   assign trk.coin_lane_o    = coin_lane_q;
   assign trk.coin_visible_o = coin_visible_q;
   assign trk.coin_hit_o     = coin_hit_q;
   assign trk.score_o        = score_q;
   assign trk.misses_o       = misses_q;
   assign trk.game_over_o    = game_over_q;

endmodule

// File: tb/tb_coin_track.sv
// Scoreboard bench for coin_track: stimulus queues expected snapshots and
// hit scores; monitors compare them against what the tracker presents.
module tb_coin_track;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   coin_if bus();

   coin_track dut (
      .clk (clk),
      .rst (rst),
      .trk (bus)
   );

   typedef struct {
      string name;
      int    loc;
      int    lane;   // -1 means do not care
      bit    vis;
      int    score;
      int    misses;
      bit    go;
   } snap_t;

   snap_t snap_q[$];
   int    hit_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   // Hit monitor: every coin_hit cycle must match one queued hit.
   always @(negedge clk) begin
      if (bus.coin_hit_o) begin
         n_cmp++;
         if (hit_q.size() == 0) begin
            n_bad++;
            $display("FAIL hit_pulse: coin_hit=1 score=%0d, required no pulse", bus.score_o);
         end else begin
            int e;
            e = hit_q.pop_front();
            if (int'(bus.score_o) != e) begin
               n_bad++;
               $display("FAIL hit_score: score=%0d, required %0d", bus.score_o, e);
            end else begin
               $display("pass hit_score: score=%0d", bus.score_o);
            end
         end
      end
   end

   // Snapshot monitor: compares every queued expectation against the outputs.
   always @(negedge clk) begin
      while (snap_q.size() > 0) begin
         snap_t s;
         s = snap_q.pop_front();
         n_cmp++;
         if (int'(bus.coinloc_o) != s.loc || (s.lane >= 0 && int'(bus.coin_lane_o) != s.lane) ||
             bus.coin_visible_o != s.vis || int'(bus.score_o) != s.score ||
             int'(bus.misses_o) != s.misses || bus.game_over_o != s.go) begin
            n_bad++;
            $display("FAIL %s: loc=%0d lane=%0d vis=%0b score=%0d misses=%0d go=%0b, required loc=%0d lane=%0d vis=%0b score=%0d misses=%0d go=%0b",
                     s.name, bus.coinloc_o, bus.coin_lane_o, bus.coin_visible_o, bus.score_o,
                     bus.misses_o, bus.game_over_o, s.loc, s.lane, s.vis, s.score, s.misses, s.go);
         end else begin
            $display("pass %s: loc=%0d lane=%0d vis=%0b score=%0d misses=%0d go=%0b",
                     s.name, bus.coinloc_o, bus.coin_lane_o, bus.coin_visible_o, bus.score_o,
                     bus.misses_o, bus.game_over_o);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      bus.frame_tick_i = 1'b1;
      @(negedge clk);
      bus.frame_tick_i = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic expect_snap(input string nm, input int loc, input int lane, input bit vis,
                              input int sc, input int mi, input bit go);
      snap_t s;
      s.name = nm; s.loc = loc; s.lane = lane; s.vis = vis;
      s.score = sc; s.misses = mi; s.go = go;
      snap_q.push_back(s);
      for (int i = 0; i < 3; i++) begin
         if (snap_q.size() == 0) break;
         @(negedge clk);
      end
      if (snap_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: %0d snapshots unchecked, required 0", nm, snap_q.size());
         snap_q.delete();
      end
   endtask

   task automatic hit_done(input string nm);
      @(negedge clk);
      n_cmp++;
      if (hit_q.size() != 0) begin
         n_bad++;
         $display("FAIL %s: %0d hit pulses missing, required 0", nm, hit_q.size());
         hit_q.delete();
      end
   endtask

   initial begin
      rst                = 1'b1;
      bus.frame_tick_i   = 1'b0;
      bus.enable_i       = 1'b0;
      bus.player_lane_i  = 2'd0;
      bus.rand_i         = 4'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      expect_snap("reset", -50, 1, 0, 0, 0, 0);

      // Spawn: delay 2, lane 2
      bus.enable_i = 1'b1;
      bus.rand_i   = 4'b0110;
      tick();
      expect_snap("idle_to_wait", -50, 1, 0, 0, 0, 0);
      tick();
      expect_snap("wait_tick1", -50, 1, 0, 0, 0, 0);
      tick();
      expect_snap("spawn", 0, 2, 1, 0, 0, 0);
      ticks(30);
      expect_snap("move30", 30, 2, 1, 0, 0, 0);

      // Enable drop mid-MOVE
      @(negedge clk);
      bus.enable_i = 1'b0;
      @(negedge clk);
      expect_snap("enable_drop", -50, -1, 0, 0, 0, 0);
      tick();
      expect_snap("idle_tick_disabled", -50, -1, 0, 0, 0, 0);

      // Hit at HIT_LO, lane 3 treated as centre
      bus.enable_i      = 1'b1;
      bus.rand_i        = 4'b0111;
      bus.player_lane_i = 2'd3;
      ticks(3);
      expect_snap("spawn_lane3_map", 0, 1, 1, 0, 0, 0);
      ticks(50);
      expect_snap("at50", 50, 1, 1, 0, 0, 0);
      hit_q.push_back(1);
      tick();
      hit_done("hit_lo_pulse");
      expect_snap("after_hit_lo", -50, -1, 0, 1, 0, 0);

      // Hit at HIT_HI after passing the window in another lane
      bus.rand_i        = 4'b0110;
      bus.player_lane_i = 2'd0;
      ticks(2);
      expect_snap("spawn2", 0, 2, 1, 1, 0, 0);
      ticks(55);
      expect_snap("at55_no_hit", 55, 2, 1, 1, 0, 0);
      bus.player_lane_i = 2'd2;
      hit_q.push_back(2);
      tick();
      hit_done("hit_hi_pulse");
      expect_snap("after_hit_hi", -50, -1, 0, 2, 0, 0);

      // Just past the window: no hit, then miss at END_LOC-1
      bus.player_lane_i = 2'd0;
      ticks(2);
      ticks(56);
      bus.player_lane_i = 2'd2;
      tick();
      expect_snap("at57_no_hit", 57, 2, 1, 2, 0, 0);
      ticks(2);
      expect_snap("at59", 59, 2, 1, 2, 0, 0);
      tick();
      expect_snap("miss1", -50, -1, 0, 2, 1, 0);

      // Saturation
      @(negedge clk);
      force dut.score_q = 16'hFFFF;
      @(negedge clk);
      release dut.score_q;
      expect_snap("score_forced", -50, -1, 0, 65535, 1, 0);
      ticks(2);
      ticks(50);
      expect_snap("sat_at50", 50, 2, 1, 65535, 1, 0);
      hit_q.push_back(65535);
      tick();
      hit_done("sat_hit_pulse");
      expect_snap("sat_after_hit", -50, -1, 0, 65535, 1, 0);

      // Misses to game over
      bus.player_lane_i = 2'd0;
      ticks(62);
      expect_snap("miss2", -50, -1, 0, 65535, 2, 0);
      ticks(62);
      expect_snap("miss3_over", -50, -1, 0, 65535, 3, 1);
      ticks(5);
      bus.enable_i = 1'b0;
      ticks(2);
      bus.enable_i = 1'b1;
      bus.rand_i   = 4'b0000;
      ticks(3);
      expect_snap("over_frozen", -50, -1, 0, 65535, 3, 1);

      // Async reset between edges while in OVER
      @(posedge clk);
      #2 rst = 1'b1;
      expect_snap("async_rst_over", -50, 1, 0, 0, 0, 0);
      rst = 1'b0;
      bus.rand_i = 4'b0110;
      ticks(3);
      expect_snap("respawn", 0, 2, 1, 0, 0, 0);
      ticks(10);
      expect_snap("move10", 10, 2, 1, 0, 0, 0);

      // Async reset mid-MOVE
      @(posedge clk);
      #2 rst = 1'b1;
      expect_snap("async_rst_move", -50, 1, 0, 0, 0, 0);
      rst = 1'b0;
      tick();
      expect_snap("post_rst_tick", -50, 1, 0, 0, 0, 0);

      hit_done("no_stray_hits");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
